// File: rtl/ttt_move_engine.sv
// Computer-move generator for an N x N tic-tac-toe board.
// On start it snapshots both occupancy masks, then scans all lines for a
// winning move, then for a blocking move, then falls back to a positional
// pick (centre, corners, first free). The result is a registered one-hot cell.
module ttt_move_engine #(
  parameter int unsigned N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [N*N-1:0]   human_mask,
  input  logic [N*N-1:0]   comp_mask,
  output logic             busy,
  output logic             move_valid,
  output logic [N*N-1:0]   move_onehot,
  output logic             no_move
);

  localparam int unsigned CELLS  = N * N;
  localparam int unsigned L      = 2 * N + 2;
  localparam int unsigned LW     = $clog2(L);
  localparam int unsigned CW     = $clog2(N + 1);
  localparam int unsigned CENTRE = (CELLS - 1) / 2;

  localparam logic [CELLS-1:0] CENTRE_BIT = CELLS'(1) << CENTRE;
  localparam logic [CELLS-1:0] CORNER0    = CELLS'(1);
  localparam logic [CELLS-1:0] CORNER1    = CELLS'(1) << (N - 1);
  localparam logic [CELLS-1:0] CORNER2    = CELLS'(1) << (CELLS - N);
  localparam logic [CELLS-1:0] CORNER3    = CELLS'(1) << (CELLS - 1);

  typedef enum logic [2:0] {StIdle, StWin, StBlock, StPick, StEmit} state_e;

  // Cell membership of every line: rows, columns, main diagonal, anti-diagonal.
  function automatic logic [L-1:0][CELLS-1:0] build_lines();
    logic [L-1:0][CELLS-1:0] lines;
    lines = '0;
    for (int unsigned r = 0; r < N; r++) begin
      for (int unsigned c = 0; c < N; c++) begin
        lines[r][r*N+c]   = 1'b1;
        lines[N+c][r*N+c] = 1'b1;
      end
      lines[2*N][r*N+r]         = 1'b1;
      lines[2*N+1][r*N+N-1-r]   = 1'b1;
    end
    return lines;
  endfunction

  localparam logic [L-1:0][CELLS-1:0] LINES = build_lines();

  // Population count; only ever applied to a single line, so N fits in CW bits.
  function automatic logic [CW-1:0] popcnt(input logic [CELLS-1:0] v);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < CELLS; i++) begin
      cnt = cnt + CW'(v[i]);
    end
    return cnt;
  endfunction

  state_e           state_q, state_d;
  logic [LW-1:0]    idx_q, idx_d;
  logic             mode_q, mode_d;
  logic [CELLS-1:0] hum_q, hum_d;
  logic [CELLS-1:0] comp_q, comp_d;
  logic [CELLS-1:0] onehot_q, onehot_d;
  logic             no_move_q, no_move_d;

  logic [CELLS-1:0] occ;
  logic [CELLS-1:0] empty_all;
  logic [CELLS-1:0] line_sel;
  logic [CELLS-1:0] empty_line;
  logic [CW-1:0]    hum_cnt;
  logic [CW-1:0]    comp_cnt;
  logic [CW-1:0]    empty_cnt;
  logic [CW-1:0]    own_cnt;
  logic [CW-1:0]    opp_cnt;
  logic             line_hit;
  logic             last_line;
  logic [CELLS-1:0] first_free;
  logic [CELLS-1:0] pick;

  // Evaluate the currently indexed line; BLOCK swaps the player roles.
  always_comb begin
    occ        = hum_q | comp_q;
    line_sel   = LINES[idx_q];
    empty_line = ~occ & line_sel;
    hum_cnt    = popcnt(hum_q & line_sel);
    comp_cnt   = popcnt(comp_q & line_sel);
    empty_cnt  = popcnt(empty_line);
    if (state_q == StBlock) begin
      own_cnt = hum_cnt;
      opp_cnt = comp_cnt;
    end else begin
      own_cnt = comp_cnt;
      opp_cnt = hum_cnt;
    end
    line_hit  = (own_cnt == CW'(N - 1)) && (opp_cnt == '0) && (empty_cnt == CW'(1));
    last_line = (idx_q == LW'(L - 1));
  end

  // Positional fallback over the snapshot; lowest set bit isolates first free.
  always_comb begin
    empty_all  = ~(hum_q | comp_q);
    first_free = empty_all & (~empty_all + CELLS'(1));
    pick       = first_free;
    if (mode_q) begin
      if (((N % 2) == 1) && |(empty_all & CENTRE_BIT)) begin
        pick = CENTRE_BIT;
      end else if (|(empty_all & CORNER0)) begin
        pick = CORNER0;
      end else if (|(empty_all & CORNER1)) begin
        pick = CORNER1;
      end else if (|(empty_all & CORNER2)) begin
        pick = CORNER2;
      end else if (|(empty_all & CORNER3)) begin
        pick = CORNER3;
      end
    end
  end

  // Next-state logic for the scan FSM and the captured snapshot.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    hum_d     = hum_q;
    comp_d    = comp_q;
    onehot_d  = onehot_q;
    no_move_d = no_move_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d    = mode;
          hum_d     = human_mask;
          comp_d    = comp_mask;
          onehot_d  = '0;
          no_move_d = 1'b0;
          idx_d     = '0;
          if (&(human_mask | comp_mask)) begin
            no_move_d = 1'b1;
            state_d   = StEmit;
          end else if (!mode) begin
            state_d = StPick;
          end else begin
            state_d = StWin;
          end
        end
      end
      StWin, StBlock: begin
        if (line_hit) begin
          onehot_d = empty_line;
          state_d  = StEmit;
        end else if (last_line) begin
          idx_d   = '0;
          state_d = (state_q == StWin) ? StBlock : StPick;
        end else begin
          idx_d = idx_q + LW'(1);
        end
      end
      StPick: begin
        onehot_d = pick;
        state_d  = StEmit;
      end
      StEmit: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and snapshot registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      mode_q    <= 1'b0;
      hum_q     <= '0;
      comp_q    <= '0;
      onehot_q  <= '0;
      no_move_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      hum_q     <= hum_d;
      comp_q    <= comp_d;
      onehot_q  <= onehot_d;
      no_move_q <= no_move_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign move_valid  = (state_q == StEmit);
  assign move_onehot = onehot_q;
  assign no_move     = no_move_q;

endmodule

// File: doc/ttt_move_engine.md
# ttt_move_engine

Parametrised computer-move generator for the N×N tic-tac-toe board. On a start pulse it snapshots both players' occupancy masks and selects one empty cell. In strategy mode the priority is: win, block, centre, corner, first free. In simple mode it takes the first free cell. It sits between the board/turn controller and the per-cell button-press logic, driving a one-hot move that is registered and handshaked.

## Interface
- `N`, default 3: board dimension, legal range 3..8.
- Derived, not overridable: `CELLS = N*N`; `L = 2N+2` lines; `LW = clog2(L)`; `CW = clog2(N+1)`.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a move; sampled only in IDLE.
- `mode`  in  1  0 = first-free, 1 = strategy; captured with `start`.
- `human_mask`  in  CELLS  bit k = human mark in cell k (k = r*N+c); captured with `start`.
- `comp_mask`  in  CELLS  bit k = computer mark in cell k; captured with `start`.
- `busy`  out  1  high in every state except IDLE.
- `move_valid`  out  1  one-cycle pulse: result available.
- `move_onehot`  out  CELLS  selected cell; held until next accepted `start`.
- `no_move`  out  1  with `move_valid`: board full, `move_onehot` = 0.

## Operation
- States: IDLE, WIN, BLOCK, PICK, EMIT.
- occupied = human | comp, bitwise. A cell set in both masks counts as occupied and is counted for both players.
- Line order:
  - lines 0..N-1: rows;
  - lines N..2N-1: columns;
  - line 2N: main diagonal (0, N+1, …);
  - line 2N+1: anti-diagonal (N-1, 2N-2, …).
- IDLE + `start`:
  - capture `mode` and both masks;
  - clear `move_onehot` and `no_move`;
  - board full → EMIT with `no_move` = 1;
  - else `mode` = 0 → PICK;
  - else → WIN with line index 0.
- WIN, one line per cycle:
  - hit = computer count == N-1, human count == 0, one empty cell;
  - on hit, register that empty cell → EMIT;
  - on miss, increment index; after line L-1 misses → BLOCK with index 0.
- BLOCK: same scan with the roles swapped (human count N-1, computer count 0). After line L-1 misses → PICK.
- PICK, one cycle, combinational priority over the captured snapshot:
  - `mode` 1: centre cell (N odd only), then corners in order 0, N-1, CELLS-N, CELLS-1, then lowest-index empty;
  - `mode` 0: lowest-index empty.
  - Result registered → EMIT.
- EMIT: `move_valid` = 1 for exactly one cycle → IDLE.
- `start` outside IDLE is ignored, not queued. Mask changes after capture are ignored.
- Counts are CW bits wide and saturate naturally: the maximum is N.

## Timing
- Reset, asynchronous: state IDLE, index 0, snapshot 0, `busy` = 0, `move_valid` = 0, `no_move` = 0, `move_onehot` = 0.
- Edge E0 is the edge that samples `start`. "Valid after Ex" means `move_valid` is high in the cycle following edge Ex.
- Full board: valid after E0, either mode.
- `mode` 0: valid after E1.
- Win on line k: valid after E(k+1).
- Block on line k: valid after E(L+k+1).
- No win and no block: valid after E(2L+1). For N = 3 this is E17.
- `busy` rises after E0. It falls after the edge that leaves EMIT, so it is still high during the `move_valid` cycle.
- Next `start` is accepted at the edge after `busy` falls. A back-to-back `start` held high is accepted on the first IDLE cycle.
- Reset asserted mid-scan: returns to IDLE immediately, clears all outputs, and no `move_valid` is produced.

## Test plan
All scenarios use N = 3. Cells a..i map to bits 0..8.

1. Assert reset, then release with `start` = 0 → all outputs 0 for 5 cycles.
2. `mode` 0, both masks 0, pulse `start` → valid after E1, `move_onehot` = 9'h001, `no_move` = 0; `busy` low the cycle after.
3. `mode` 1, `comp_mask` = 9'h003, `human_mask` = 9'h018 → win on line 0 takes priority over block on line 1; valid after E1, `move_onehot` = 9'h004.
4. `mode` 1, `comp_mask` = 9'h002, `human_mask` = 9'h011 → block on line 6; valid after E15, `move_onehot` = 9'h100.
5. `mode` 1, `human_mask` = 9'h001, `comp_mask` = 0 → centre, valid after E17, `move_onehot` = 9'h010. Repeat with `human_mask` = 9'h010 → corner, `move_onehot` = 9'h001.
6. Edge and abort cases:
   - `comp_mask` = 9'h155, `human_mask` = 9'h0AA → valid after E0 with `no_move` = 1 and `move_onehot` = 0.
   - Repeat case 5 with `start` re-pulsed while busy → ignored, single `move_valid`.
   - Repeat case 5 with `rst_n` low at E5 → no `move_valid`, all outputs 0.
